// File: rtl/bcd_converter_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/done handshake,
// overflow saturation and a leading-zero blanking mask for the display driver.
module bcd_converter_seq #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int CW  = $clog2(BIN_WIDTH + 1);
  localparam int BCW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_INIT = CW'(BIN_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCW-1:0]       work_q, work_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [BCW-1:0]       bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [DIGITS-1:0]    en_q, en_d;

  logic [BCW-1:0]       adj_s;
  logic [BCW-1:0]       final_s;
  logic [DIGITS-1:0]    en_s;

  // Per-digit +3 correction; digits never carry into each other.
  function automatic logic [BCW-1:0] add3_digits(input logic [BCW-1:0] w);
    logic [BCW-1:0] r;
    r = w;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = w[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = w[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Final digits and the blanking mask derived from them.
  always_comb begin
    adj_s   = add3_digits(work_q);
    final_s = sticky_q ? {DIGITS{4'h9}} : work_q;
    en_s    = '0;
    en_s[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      en_s[i] = |(final_s >> (4 * i));
    end
  end

  // Next-state logic: accept, shift BIN_WIDTH times, then publish results.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    en_d     = en_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d    = bin_in;
          work_d   = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_INIT;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        work_d   = {adj_s[BCW-2:0], bin_q[BIN_WIDTH-1]};
        bin_d    = bin_q << 1;
        sticky_d = sticky_q | adj_s[BCW-1];
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        bcd_d   = final_s;
        ovf_d   = sticky_q;
        en_d    = en_s;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, working and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      en_q     <= DIGITS'(1);
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
  assign digit_en = en_q;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Scoreboard bench for bcd_converter_seq: a default 14-bit/4-digit instance and a
// 4-bit/2-digit instance, checked against an arithmetic reference model.
module tb_bcd_converter_seq;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  en;
  } exp_a_t;

  typedef struct packed {
    logic [7:0] bcd;
    logic       ovf;
    logic [1:0] en;
  } exp_b_t;

  logic clock = 1'b0;
  logic reset_n;

  logic        start_a;
  logic [13:0] bin_a;
  logic        busy_a, done_a, ovf_a;
  logic [15:0] bcd_a;
  logic [3:0]  en_a;

  logic        start_b;
  logic [3:0]  bin_b;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;
  logic [1:0]  en_b;

  exp_a_t q_a[$];
  exp_b_t q_b[$];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  bcd_converter_seq #(.BIN_WIDTH(14), .DIGITS(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a), .digit_en(en_a)
  );

  bcd_converter_seq #(.BIN_WIDTH(4), .DIGITS(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b), .digit_en(en_b)
  );

  function automatic exp_a_t ref_a(input int v);
    exp_a_t e;
    int p;
    e.ovf = (v > 9999);
    e.bcd = '0;
    e.en  = 4'b0001;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      e.bcd[4*i +: 4] = e.ovf ? 4'h9 : 4'((v / p) % 10);
      if (i > 0 && (e.ovf || v >= p)) e.en[i] = 1'b1;
      p = p * 10;
    end
    return e;
  endfunction

  function automatic exp_b_t ref_b(input int v);
    exp_b_t e;
    e.ovf = 1'b0;
    e.bcd = {4'(v / 10), 4'(v % 10)};
    e.en  = (v >= 10) ? 2'b11 : 2'b01;
    return e;
  endfunction

  task automatic launch_a(input int v);
    @(negedge clock);
    bin_a   = 14'(v);
    start_a = 1'b1;
    q_a.push_back(ref_a(v));
    @(posedge clock);
    #1;
    start_a = 1'b0;
  endtask

  // Called just after the accepting edge; waits for done and checks the popped entry.
  task automatic collect_a(input int disturb, output int lat, output int busy_cnt);
    exp_a_t e;
    lat = 0;
    busy_cnt = busy_a ? 1 : 0;
    while (!done_a && lat < 60) begin
      @(posedge clock);
      #1;
      lat++;
      if (busy_a) busy_cnt++;
      if (disturb > 0 && lat == disturb) begin
        start_a = 1'b1;
        bin_a   = 14'd42;
      end else if (disturb > 0 && lat == disturb + 1) begin
        start_a = 1'b0;
      end
    end
    checks++;
    if (!done_a) begin
      errors++;
      $display("FAIL done_timeout_a: no done after %0d cycles", lat);
    end else if (q_a.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_a: done with empty queue");
    end else begin
      e = q_a.pop_front();
      checks++;
      if (bcd_a !== e.bcd) begin
        errors++;
        $display("FAIL bcd_a: got %h expected %h", bcd_a, e.bcd);
      end
      checks++;
      if (ovf_a !== e.ovf) begin
        errors++;
        $display("FAIL ovf_a: got %b expected %b", ovf_a, e.ovf);
      end
      checks++;
      if (en_a !== e.en) begin
        errors++;
        $display("FAIL en_a: got %b expected %b", en_a, e.en);
      end
    end
  endtask

  task automatic check_lat_a(input int lat);
    checks++;
    if (lat !== 15) begin
      errors++;
      $display("FAIL latency_a: got %0d expected 15", lat);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start_a = 1'b0; bin_a = '0;
    start_b = 1'b0; bin_b = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy_a, done_a, bcd_a, ovf_a, en_a} !== {1'b0, 1'b0, 16'h0000, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_a: got %b %b %h %b %b expected 0 0 0000 0 0001",
               busy_a, done_a, bcd_a, ovf_a, en_a);
    end
    checks++;
    if ({busy_b, done_b, bcd_b, ovf_b, en_b} !== {1'b0, 1'b0, 8'h00, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL reset_b: got %b %b %h %b %b expected 0 0 00 0 01",
               busy_b, done_b, bcd_b, ovf_b, en_b);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_zero;
    int lat, bc;
    launch_a(0);
    collect_a(0, lat, bc);
    check_lat_a(lat);
    @(posedge clock);
    #1;
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got %b expected 0", done_a);
    end
  endtask

  task automatic test_max_and_overflow;
    int lat, bc;
    launch_a(9999);
    collect_a(0, lat, bc);
    check_lat_a(lat);
    checks++;
    if (bc !== 15) begin
      errors++;
      $display("FAIL busy_cycles: got %0d expected 15", bc);
    end
    launch_a(16383);
    collect_a(0, lat, bc);
    check_lat_a(lat);
    launch_a(10000);
    collect_a(0, lat, bc);
  endtask

  task automatic test_ignore_while_busy;
    int lat, bc;
    launch_a(305);
    collect_a(5, lat, bc);
    check_lat_a(lat);
    @(posedge clock);
    #1;
    checks++;
    if (busy_a !== 1'b0 || q_a.size() != 0) begin
      errors++;
      $display("FAIL ignored_start: busy %b queue %0d expected 0 0", busy_a, q_a.size());
    end
  endtask

  task automatic test_sweep_b;
    exp_b_t e;
    int lat;
    for (int v = 0; v < 16; v++) begin
      @(negedge clock);
      bin_b   = 4'(v);
      start_b = 1'b1;
      q_b.push_back(ref_b(v));
      @(posedge clock);
      #1;
      start_b = 1'b0;
      lat = 0;
      while (!done_b && lat < 20) begin
        @(posedge clock);
        #1;
        lat++;
      end
      e = q_b.pop_front();
      checks++;
      if (!done_b || lat !== 5) begin
        errors++;
        $display("FAIL latency_b v=%0d: got %0d expected 5", v, lat);
      end
      checks++;
      if ({bcd_b, ovf_b, en_b} !== {e.bcd, e.ovf, e.en}) begin
        errors++;
        $display("FAIL sweep_b v=%0d: got %h %b %b expected %h %b %b",
                 v, bcd_b, ovf_b, en_b, e.bcd, e.ovf, e.en);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    @(negedge clock);
    bin_a   = 14'd4321;
    start_a = 1'b1;
    q_a.push_back(ref_a(4321));
    @(posedge clock);
    #1;
    bin_a = 14'd87;
    q_a.push_back(ref_a(87));
    collect_a(0, lat, bc);
    check_lat_a(lat);
    @(posedge clock);
    #1;
    bin_a = 14'd7008;
    q_a.push_back(ref_a(7008));
    collect_a(0, lat, bc);
    check_lat_a(lat);
    @(posedge clock);
    #1;
    start_a = 1'b0;
    bin_a   = 14'd1;
    collect_a(0, lat, bc);
    check_lat_a(lat);
  endtask

  task automatic test_abort;
    int lat, bc, seen;
    exp_a_t junk;
    seen = 0;
    launch_a(1234);
    repeat (7) begin
      @(posedge clock);
      #1;
      if (done_a) seen++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, bcd_a, ovf_a, en_a} !== {1'b0, 1'b0, 16'h0000, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL abort_reset: got %b %b %h %b %b expected 0 0 0000 0 0001",
               busy_a, done_a, bcd_a, ovf_a, en_a);
    end
    junk = q_a.pop_back();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (done_a) seen++;
    end
    checks++;
    if (seen !== 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses %0d busy %b expected 0 0", seen, busy_a);
    end
    launch_a(60);
    collect_a(0, lat, bc);
    check_lat_a(lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero();
    test_max_and_overflow();
    test_ignore_while_busy();
    test_sweep_b();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
